ram_arbiter: RTL

Two-port arbiter and access sequencer for the team's single-port RAM array, which is built from RAM cells and uses registered reads.
- Accepts read/write commands from two requesters (A and B) and grants one at a time.
- Drives the RAM's write_en/read_en/address/data strobes for exactly one cycle per access.
- Returns read data to the granted requester.
- Sits between bus-side masters and the memory array.

---
 rtl/ram_arbiter_if.sv | 46 ++++
 rtl/ram_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Requester/arbiter/RAM signal bundle for ram_arbiter.
// slave  : arbiter view (commands in, grants/read data/RAM strobes out)
// master : requester view (commands out, grants/read data in)
// ram    : memory array view (strobes in, read data out)
interface ram_arbiter_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
);
   logic              req_a;
   logic              req_b;
   logic              write_a;
   logic              write_b;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] wdata_a;
   logic [DATA_W-1:0] wdata_b;
   logic              gnt_a;
   logic              gnt_b;
   logic              rvalid_a;
   logic              rvalid_b;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic              mem_write_en;
   logic              mem_read_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;
   logic              busy;

   modport slave (
      input  req_a, req_b, write_a, write_b, addr_a, addr_b, wdata_a, wdata_b,
      input  mem_read_data,
      output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
      output mem_write_en, mem_read_en, mem_addr, mem_write_data, busy
   );

   modport master (
      output req_a, req_b, write_a, write_b, addr_a, addr_b, wdata_a, wdata_b,
      input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, busy
   );

   modport ram (
      input  mem_write_en, mem_read_en, mem_addr, mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter and access sequencer for a single-port RAM with
// registered reads. One access in flight at a time; all outputs registered.
// Optional macro ROUND_ROBIN_EN: ties go to the port not granted most
// recently. Without it, port A always wins ties (fixed priority).
module ram_arbiter #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input logic          clk,
   input logic          rst,
   ram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RDWAIT = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              lat_b_q, lat_b_d;          // latched winner: 1 = port B
   logic              lat_write_q, lat_write_d;  // latched command is a write
   logic              gnt_a_q, gnt_a_d;
   logic              gnt_b_q, gnt_b_d;
   logic              rvalid_a_q, rvalid_a_d;
   logic              rvalid_b_q, rvalid_b_d;
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
   logic              mem_write_en_q, mem_write_en_d;
   logic              mem_read_en_q, mem_read_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
   logic              busy_q, busy_d;
   logic              pick_b_c;

`ifdef ROUND_ROBIN_EN
   logic              last_b_q, last_b_d;        // most recent grant went to B

   // Winner select: a tie goes to whichever port was not granted last
   always_comb begin
      pick_b_c = bus.req_b && (!bus.req_a || !last_b_q);
   end
`else
   // Winner select: A has fixed priority on a tie
   always_comb begin
      pick_b_c = bus.req_b && !bus.req_a;
   end
`endif

   // Next-state and next-output computation
   always_comb begin
      state_d          = state_q;
      lat_b_d          = lat_b_q;
      lat_write_d      = lat_write_q;
      gnt_a_d          = 1'b0;
      gnt_b_d          = 1'b0;
      rvalid_a_d       = 1'b0;
      rvalid_b_d       = 1'b0;
      rdata_a_d        = rdata_a_q;
      rdata_b_d        = rdata_b_q;
      mem_write_en_d   = 1'b0;
      mem_read_en_d    = 1'b0;
      mem_addr_d       = mem_addr_q;
      mem_write_data_d = mem_write_data_q;
`ifdef ROUND_ROBIN_EN
      last_b_d         = last_b_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (bus.req_a || bus.req_b) begin
               lat_b_d          = pick_b_c;
               lat_write_d      = pick_b_c ? bus.write_b : bus.write_a;
               mem_addr_d       = pick_b_c ? bus.addr_b  : bus.addr_a;
               mem_write_data_d = pick_b_c ? bus.wdata_b : bus.wdata_a;
               gnt_a_d          = !pick_b_c;
               gnt_b_d          = pick_b_c;
               mem_write_en_d   = lat_write_d;
               mem_read_en_d    = !lat_write_d;
               state_d          = ST_ACCESS;
`ifdef ROUND_ROBIN_EN
               last_b_d         = pick_b_c;
`endif
            end
         end
         ST_ACCESS: begin
            state_d = lat_write_q ? ST_IDLE : ST_RDWAIT;
         end
         ST_RDWAIT: begin
            // RAM read data is valid this cycle; route it to the requester
            state_d = ST_IDLE;
            if (lat_b_q) begin
               rvalid_b_d = 1'b1;
               rdata_b_d  = bus.mem_read_data;
            end else begin
               rvalid_a_d = 1'b1;
               rdata_a_d  = bus.mem_read_data;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         lat_b_q          <= 1'b0;
         lat_write_q      <= 1'b0;
         gnt_a_q          <= 1'b0;
         gnt_b_q          <= 1'b0;
         rvalid_a_q       <= 1'b0;
         rvalid_b_q       <= 1'b0;
         rdata_a_q        <= '0;
         rdata_b_q        <= '0;
         mem_write_en_q   <= 1'b0;
         mem_read_en_q    <= 1'b0;
         mem_addr_q       <= '0;
         mem_write_data_q <= '0;
         busy_q           <= 1'b0;
`ifdef ROUND_ROBIN_EN
         last_b_q         <= 1'b1;
`endif
      end else begin
         state_q          <= state_d;
         lat_b_q          <= lat_b_d;
         lat_write_q      <= lat_write_d;
         gnt_a_q          <= gnt_a_d;
         gnt_b_q          <= gnt_b_d;
         rvalid_a_q       <= rvalid_a_d;
         rvalid_b_q       <= rvalid_b_d;
         rdata_a_q        <= rdata_a_d;
         rdata_b_q        <= rdata_b_d;
         mem_write_en_q   <= mem_write_en_d;
         mem_read_en_q    <= mem_read_en_d;
         mem_addr_q       <= mem_addr_d;
         mem_write_data_q <= mem_write_data_d;
         busy_q           <= busy_d;
`ifdef ROUND_ROBIN_EN
         last_b_q         <= last_b_d;
`endif
      end
   end

   assign bus.gnt_a          = gnt_a_q;
   assign bus.gnt_b          = gnt_b_q;
   assign bus.rvalid_a       = rvalid_a_q;
   assign bus.rvalid_b       = rvalid_b_q;
   assign bus.rdata_a        = rdata_a_q;
   assign bus.rdata_b        = rdata_b_q;
   assign bus.mem_write_en   = mem_write_en_q;
   assign bus.mem_read_en    = mem_read_en_q;
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_write_data = mem_write_data_q;
   assign bus.busy           = busy_q;

endmodule
